// File: rtl/memory_responder.sv
// Byte-addressed big-endian data memory with a fixed-latency MFC handshake.
// Executes SPARC load/store op3 codes; misaligned or unsupported accesses raise Fault.
module memory_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RAM_enable,
  input  logic [5:0]        RAM_OpCode,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              mfc_next, fault_next;
  logic [31:0]       dout_next;
  logic              accept, commit;

  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  logic              is_load, is_store, is_signed, op_ok, acc_fault;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr1, addr2, addr3;
  logic [7:0]        rd0, rd1, rd2, rd3;
  logic [31:0]       load_val;

  assign addr1 = addr_q + ADDR_W'(1);
  assign addr2 = addr_q + ADDR_W'(2);
  assign addr3 = addr_q + ADDR_W'(3);
  assign rd0   = mem[addr_q];
  assign rd1   = mem[addr1];
  assign rd2   = mem[addr2];
  assign rd3   = mem[addr3];

  // Decode works on the latched opcode/address so inputs may change during BUSY.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    op_ok     = 1'b1;
    size      = SZ_WORD;
    case (op_q)
      6'b000000: begin is_load = 1'b1; size = SZ_WORD; end
      6'b000001: begin is_load = 1'b1; size = SZ_BYTE; end
      6'b000010: begin is_load = 1'b1; size = SZ_HALF; end
      6'b001001: begin is_load = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
      6'b001010: begin is_load = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
      6'b000100: begin is_store = 1'b1; size = SZ_WORD; end
      6'b000101: begin is_store = 1'b1; size = SZ_BYTE; end
      6'b000110: begin is_store = 1'b1; size = SZ_HALF; end
      default:   op_ok = 1'b0;
    endcase
    acc_fault = !op_ok
              || (size == SZ_HALF && addr_q[0])
              || (size == SZ_WORD && addr_q[1:0] != 2'b00);

    case (size)
      SZ_BYTE: load_val = {{24{is_signed & rd0[7]}}, rd0};
      SZ_HALF: load_val = {{16{is_signed & rd0[7]}}, rd0, rd1};
      default: load_val = {rd0, rd1, rd2, rd3};
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mfc_next   = MFC;
    fault_next = Fault;
    dout_next  = DataOut;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        mfc_next = 1'b0;
        if (RAM_enable) begin
          accept     = 1'b1;
          cnt_next   = 4'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          mfc_next   = 1'b1;
          fault_next = acc_fault;
          if (is_load && !acc_fault) dout_next = load_val;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        if (!RAM_enable) begin
          mfc_next   = 1'b0;
          fault_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      MFC     <= 1'b0;
      Fault   <= 1'b0;
      DataOut <= 32'h0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      MFC     <= mfc_next;
      Fault   <= fault_next;
      DataOut <= dout_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= 6'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      op_q    <= RAM_OpCode;
      addr_q  <= Address;
      wdata_q <= DataIn;
    end
  end

  // Memory is never cleared; reset only blocks a store that would commit on this edge.
  always_ff @(posedge clk) begin
    if (commit && is_store && !acc_fault && !reset) begin
      case (size)
        SZ_BYTE: mem[addr_q] <= wdata_q[7:0];
        SZ_HALF: begin
          mem[addr_q] <= wdata_q[15:8];
          mem[addr1]  <= wdata_q[7:0];
        end
        default: begin
          mem[addr_q] <= wdata_q[31:24];
          mem[addr1]  <= wdata_q[23:16];
          mem[addr2]  <= wdata_q[15:8];
          mem[addr3]  <= wdata_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: driver queues hand-computed responses,
// a monitor pops and compares them on every MFC rising edge.
module tb_memory_responder;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_SWAP = 6'b001111;

  logic              clk = 1'b0;
  logic              reset;
  logic              RAM_enable;
  logic [5:0]        RAM_OpCode;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MFC;
  logic              Fault;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .RAM_enable (RAM_enable),
    .RAM_OpCode (RAM_OpCode),
    .Address    (Address),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .MFC        (MFC),
    .Fault      (Fault)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic [7:0]  id;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every MFC rising edge must match the oldest queued response.
  logic mfc_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (MFC && !mfc_prev) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_nonempty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        checkOutput($sformatf("fault_id%0d", e.id), {31'd0, Fault}, {31'd0, e.fault});
        checkOutput($sformatf("data_id%0d", e.id), DataOut, e.data);
      end
    end
    mfc_prev = MFC;
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] din, input logic [31:0] exp_data,
                               input logic exp_fault, input int hold, input int id);
    exp_t e;
    int   cyc;
    e.data  = exp_data;
    e.fault = exp_fault;
    e.id    = 8'(id);
    sb_q.push_back(e);
    @(negedge clk);
    RAM_enable = 1'b1;
    RAM_OpCode = op;
    Address    = addr;
    DataIn     = din;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        RAM_OpCode = OP_ST;
        Address    = ~addr;
        DataIn     = ~din;
      end
    end while (!MFC && cyc < 20);
    checkOutput($sformatf("latency_id%0d", id), 32'(cyc), 32'(LATENCY + 1));
    repeat (hold) begin
      @(negedge clk);
      checkOutput($sformatf("mfc_hold_id%0d", id), {31'd0, MFC}, 32'd1);
    end
    RAM_enable = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("mfc_fall_id%0d", id), {31'd0, MFC}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   hi;
    reset      = 1'b1;
    RAM_enable = 1'b0;
    RAM_OpCode = 6'd0;
    Address    = '0;
    DataIn     = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_mfc", {31'd0, MFC}, 32'd0);
    checkOutput("reset_fault", {31'd0, Fault}, 32'd0);
    checkOutput("reset_dout", DataOut, 32'h0);
    reset = 1'b0;

    applyStimulus(OP_ST,   9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 0, 0);
    applyStimulus(OP_LD,   9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1);
    applyStimulus(OP_LDSB, 9'h010, 32'h0,        32'hFFFFFFDE, 1'b0, 0, 2);
    applyStimulus(OP_LDUB, 9'h011, 32'h0,        32'h000000AD, 1'b0, 0, 3);
    applyStimulus(OP_LDSH, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0, 0, 4);
    applyStimulus(OP_LDUH, 9'h012, 32'h0,        32'h0000BEEF, 1'b0, 0, 5);
    applyStimulus(OP_STB,  9'h011, 32'hAAAAAA12, 32'h0000BEEF, 1'b0, 0, 6);
    applyStimulus(OP_STH,  9'h012, 32'hBBBB3456, 32'h0000BEEF, 1'b0, 0, 7);
    applyStimulus(OP_LD,   9'h010, 32'h0,        32'hDE123456, 1'b0, 0, 8);
    applyStimulus(OP_LD,   9'h013, 32'h0,        32'hDE123456, 1'b1, 0, 9);
    applyStimulus(OP_LDD,  9'h010, 32'h0,        32'hDE123456, 1'b1, 0, 10);
    applyStimulus(OP_STH,  9'h011, 32'h0000FFFF, 32'hDE123456, 1'b1, 0, 11);
    applyStimulus(OP_SWAP, 9'h010, 32'h0,        32'hDE123456, 1'b1, 0, 12);
    applyStimulus(OP_LD,   9'h010, 32'h0,        32'hDE123456, 1'b0, 0, 13);
    applyStimulus(OP_LDSB, 9'h011, 32'h0,        32'h00000012, 1'b0, 0, 14);
    applyStimulus(OP_LDUB, 9'h013, 32'h0,        32'h00000056, 1'b0, 0, 15);
    applyStimulus(OP_LD,   9'h010, 32'h0,        32'hDE123456, 1'b0, 5, 16);
    applyStimulus(OP_ST,   9'h1FC, 32'h8081F0F1, 32'hDE123456, 1'b0, 0, 17);
    applyStimulus(OP_LDSH, 9'h1FE, 32'h0,        32'hFFFFF0F1, 1'b0, 0, 18);

    // Enable dropped while BUSY: access still completes, MFC is a one-cycle pulse.
    e.data  = 32'h0000DE12;
    e.fault = 1'b0;
    e.id    = 8'd19;
    sb_q.push_back(e);
    @(negedge clk);
    RAM_enable = 1'b1;
    RAM_OpCode = OP_LDUH;
    Address    = 9'h010;
    @(negedge clk);
    RAM_enable = 1'b0;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (MFC) hi++;
    end
    checkOutput("mfc_pulse_width", 32'(hi), 32'd1);

    // Reset one edge after accepting a store: store is discarded.
    applyStimulus(OP_ST, 9'h020, 32'hCAFEF00D, 32'h0000DE12, 1'b0, 0, 20);
    @(negedge clk);
    RAM_enable = 1'b1;
    RAM_OpCode = OP_ST;
    Address    = 9'h020;
    DataIn     = 32'h11111111;
    @(negedge clk);
    reset      = 1'b1;
    RAM_enable = 1'b0;
    @(negedge clk);
    checkOutput("midop_reset_mfc", {31'd0, MFC}, 32'd0);
    checkOutput("midop_reset_dout", DataOut, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midop_no_mfc", {31'd0, MFC}, 32'd0);
    applyStimulus(OP_LD, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, 0, 21);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
